rv_instr_encoder: RTL and testbench

//  Instruction-memory loader: encodes field-level requests (class, rd, rs1, rs2, funct3, funct7, imm)

---
 rtl/rv_instr_encoder.sv | 154 +++++++++++++++
 tb/tb_rv_instr_encoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder.sv
// RV32I instruction-memory loader: encodes field-level requests into 32-bit words and
// streams them with consecutive word addresses through a one-deep registered output.
module rv_instr_encoder #(
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int unsigned IMEM_WORDS = 256,
   parameter bit          WRAP_EN    = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_class,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic [31:0] out_addr,
   output logic        err,
   output logic [15:0] count,
   output logic        full
);

   localparam int unsigned   KW    = $clog2(IMEM_WORDS);
   localparam logic [KW-1:0] KLast = KW'(IMEM_WORDS - 1);

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

   state_e        state_q, state_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   word_q, word_d;
   logic [KW-1:0] k_q, k_d;
   logic [15:0]   count_q, count_d;
   logic          err_q, err_d;

   logic [31:0] enc_word;
   logic        enc_ok;
   logic        fits_i, fits_b, fits_j;
   logic        out_hs, start_take, at_last, cap_block, in_acc;

   // Signed range checks: all bits above the field width must equal the sign bit.
   assign fits_i = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign fits_b = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
   assign fits_j = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

   always_comb begin
      enc_word = '0;
      enc_ok   = 1'b0;
      case (in_class)
         3'd0: begin
            enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_RTYPE};
            enc_ok   = 1'b1;
         end
         3'd1: begin
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
            enc_ok   = fits_i;
         end
         3'd2: begin
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
            enc_ok   = fits_i;
         end
         3'd3: begin
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
            enc_ok   = fits_i;
         end
         3'd4: begin
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OPC_BRANCH};
            enc_ok   = fits_b;
         end
         3'd5: begin
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
            enc_ok   = fits_j;
         end
         3'd6: begin
            enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
            enc_ok   = fits_i;
         end
         default: ;
      endcase
   end

   assign out_hs     = out_valid_q & out_ready;
   assign start_take = start & ~out_valid_q;
   assign at_last    = (k_q == KLast);
   // Without wrap, the word at the last slot must not be followed by a new accept.
   assign cap_block  = ~WRAP_EN & out_valid_q & at_last;
   assign in_ready   = (state_q == StRun) & ~start_take & (~out_valid_q | out_ready) & ~cap_block;
   assign in_acc     = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      word_d      = word_q;
      k_d         = k_q;
      count_d     = count_q;
      err_d       = in_acc & ~enc_ok;
      if (start_take) begin
         state_d = StRun;
         k_d     = '0;
         count_d = '0;
      end else begin
         if (out_hs) begin
            out_valid_d = 1'b0;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            if (at_last && !WRAP_EN) state_d = StFull;
            else                     k_d     = k_q + KW'(1);
         end
         if (in_acc && enc_ok) begin
            out_valid_d = 1'b1;
            word_d      = enc_word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         word_q      <= '0;
         k_q         <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         word_q      <= word_d;
         k_q         <= k_d;
         count_q     <= count_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_word  = word_q;
   assign out_addr  = BASE_ADDR + {{(30 - KW){1'b0}}, k_q, 2'b00};
   assign err       = err_q;
   assign count     = count_q;
   assign full      = (state_q == StFull);

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: a wrapping instance (scoreboarded every cycle against a
// field-level encoding model) and a non-wrapping instance sharing its stimulus.
module tb_rv_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [2:0]  in_class = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [31:0] in_imm = '0;

   logic        a_in_ready, a_out_valid, a_err, a_full;
   logic [31:0] a_out_word, a_out_addr;
   logic [15:0] a_count;
   logic        b_in_ready, b_out_valid, b_err, b_full;
   logic [31:0] b_out_word, b_out_addr;
   logic [15:0] b_count;

   rv_instr_encoder #(.BASE_ADDR(32'h0), .IMEM_WORDS(4), .WRAP_EN(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_word(a_out_word),
      .out_addr(a_out_addr), .err(a_err), .count(a_count), .full(a_full)
   );

   rv_instr_encoder #(.BASE_ADDR(32'h0), .IMEM_WORDS(4), .WRAP_EN(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_word(b_out_word),
      .out_addr(b_out_addr), .err(b_err), .count(b_count), .full(b_full)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail = 0;
   int          emitted = 0;
   logic        err_exp = 1'b0;
   logic        acc = 1'b0;
   logic [31:0] q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_enc(input logic [2:0] cls, input logic [4:0] rd, rs1, rs2,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] imm, output logic [31:0] w);
      int v;
      v = int'($signed(imm));
      w = '0;
      case (cls)
         3'd0: begin w = {f7, rs2, rs1, f3, rd, 7'b0110011}; return 1'b1; end
         3'd1: begin w = {imm[11:0], rs1, f3, rd, 7'b0010011}; return v >= -2048 && v <= 2047; end
         3'd2: begin w = {imm[11:0], rs1, f3, rd, 7'b0000011}; return v >= -2048 && v <= 2047; end
         3'd3: begin
            w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            return v >= -2048 && v <= 2047;
         end
         3'd4: begin
            w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            return v >= -4096 && v <= 4094 && (v % 2) == 0;
         end
         3'd5: begin
            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            return v >= -1048576 && v <= 1048574 && (v % 2) == 0;
         end
         3'd6: begin w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111}; return v >= -2048 && v <= 2047; end
         default: return 1'b0;
      endcase
   endfunction

   // One clock: check the wrapping instance at the falling edge, update the model for the
   // coming rising edge, return 1 time unit after it.
   task automatic tick();
      logic [31:0] w;
      bit          ok;
      @(negedge clk);
      chk("out_valid", b_out_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("out_word", b_out_word, q[0]);
         chk("out_addr", b_out_addr, 32'(4 * (emitted % 4)));
         if (!out_ready) chk("in_ready_stall", b_in_ready, 0);
      end
      chk("count", b_count, emitted);
      chk("err", b_err, err_exp);
      chk("full_wrap", b_full, 0);
      err_exp = 1'b0;
      acc     = 1'b0;
      if (start && q.size() == 0) begin
         emitted = 0;
      end else begin
         if (q.size() > 0 && out_ready) begin
            void'(q.pop_front());
            emitted++;
         end
         if (in_valid && b_in_ready) begin
            acc = 1'b1;
            ok  = model_enc(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, w);
            if (ok) q.push_back(w);
            else    err_exp = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] cls, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                       output int cyc);
      in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      in_valid = 1'b1;
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("send_accept", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic do_start();
      out_ready = 1'b1;
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [31:0] rand_imm();
      int edges[14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                        1048574, -1048576, 1048576, -1048578, 0, 1};
      case ($urandom_range(0, 4))
         0:       return 32'($urandom_range(0, 4095)) - 32'd2048;
         1:       return $urandom;
         2:       return 32'(edges[$urandom_range(0, 13)]);
         3:       return 32'($urandom_range(0, 8191)) - 32'd4096;
         default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
   endfunction

   initial begin
      int c;
      // Reset values
      #12;
      chk("rst_out_valid", b_out_valid, 0);
      chk("rst_out_word", b_out_word, 0);
      chk("rst_out_addr", b_out_addr, 0);
      chk("rst_count", b_count, 0);
      chk("rst_err", b_err, 0);
      chk("rst_full", a_full, 0);
      chk("rst_in_ready", b_in_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      do_start();

      // OPIMM addi x1, x0, 5
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, c);
      chk("t1_word", b_out_word, 32'h00500093);
      chk("t1_addr", b_out_addr, 32'h0);
      tick();
      chk("t1_count", b_count, 1);

      // RTYPE then STORE back-to-back
      do_start();
      send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, c);
      chk("t2_r_word", b_out_word, 32'h002081B3);
      chk("t2_r_addr", b_out_addr, 32'h0);
      send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, c);
      chk("t2_s_cycles", c, 1);
      chk("t2_s_word", b_out_word, 32'h0020A423);
      chk("t2_s_addr", b_out_addr, 32'h4);

      // BRANCH and JAL
      send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, c);
      chk("t3_b_word", b_out_word, 32'hFE208EE3);
      send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, c);
      chk("t3_j_word", b_out_word, 32'h008000EF);
      tick();

      // Dropped requests
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, c);
      chk("t4_err0", b_err, 1);
      chk("t4_nv0", b_out_valid, 0);
      send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, c);
      chk("t4_err1", b_err, 1);
      chk("t4_nv1", b_out_valid, 0);
      send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, c);
      chk("t4_err2", b_err, 1);
      chk("t4_nv2", b_out_valid, 0);
      chk("t4_count", b_count, 4);
      chk("t4_addr", b_out_addr, 32'h0);
      tick();

      // Output backpressure
      out_ready = 1'b0;
      send(3'd1, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'd100, c);
      chk("t5_a_word", b_out_word, 32'h06430293);
      in_class = 3'd1; in_rd = 5'd7; in_rs1 = 5'd0; in_funct3 = 3'd0; in_imm = 32'hFFFFFFFF;
      in_valid = 1'b1;
      repeat (5) begin
         tick();
         chk("t5_no_accept", acc, 0);
      end
      chk("t5_held", b_out_word, 32'h06430293);
      out_ready = 1'b1;
      send(3'd1, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, c);
      chk("t5_rel_cycles", c, 1);
      chk("t5_b_word", b_out_word, 32'hFFF00393);
      tick();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_class  = 3'($urandom_range(0, 7));
         in_rd     = 5'($urandom);
         in_rs1    = 5'($urandom);
         in_rs2    = 5'($urandom);
         in_funct3 = 3'($urandom);
         in_funct7 = 7'($urandom);
         in_imm    = rand_imm();
         out_ready = ($urandom_range(0, 3) != 0);
         start     = (q.size() == 0) && ($urandom_range(0, 30) == 0);
         tick();
      end
      in_valid = 1'b0;
      start    = 1'b0;

      // Capacity: stop in FULL without wrap, wrap to base with it
      do_start();
      for (int i = 0; i < 5; i++) send(3'd1, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), c);
      chk("t6_full", a_full, 1);
      chk("t6_full_ready", a_in_ready, 0);
      chk("t6_full_count", a_count, 4);
      chk("t6_wrap_addr", b_out_addr, 32'h0);
      chk("t6_wrap_word", b_out_word, 32'h00400293);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_restart_addr", a_out_addr, 32'h0);
      chk("t6_restart_full", a_full, 0);
      chk("t6_restart_count", a_count, 0);

      // Reset in the middle of a pending word
      out_ready = 1'b0;
      send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, c);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid_b", b_out_valid, 0);
      chk("t6_rst_valid_a", a_out_valid, 0);
      chk("t6_rst_word", b_out_word, 0);
      chk("t6_rst_count", b_count, 0);
      chk("t6_rst_addr", b_out_addr, 32'h0);
      q.delete();
      emitted = 0;
      err_exp = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      chk("t6_idle_ready", b_in_ready, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
